// File: rtl/mux_n_1_pipe.sv
// N:1 channel selector with a single registered output stage and valid/ready flow control.
// Fixed-select or round-robin arbitration, chosen at run time by mode.
module mux_n_1_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  src_q, src_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SELW:0]    scan_idx;
    logic [WIDTH-1:0] grant_data;
    logic             can_accept;
    logic             in_xfer;

    // Scan index is one bit wider so ptr+k can be wrapped explicitly for non-power-of-2 N.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_idx = {1'b0, ptr_q} + (SELW+1)'(k);
                if (scan_idx >= (SELW+1)'(N)) begin
                    scan_idx = scan_idx - (SELW+1)'(N);
                end
                if (!grant_vld && in_valid[scan_idx[SELW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_accept = !valid_q || out_ready;
    assign in_xfer    = rst_n && grant_vld && can_accept;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = in_xfer && (grant_idx == SELW'(i));
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            data_d  = grant_data;
            src_d   = grant_idx;
            valid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Bench for mux_n_1_pipe: an N=4 and an N=3 instance run side by side against a
// cycle-level reference model, with directed scenarios followed by random traffic.
module tb_mux_n_1_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v_mode   [2];
    logic [1:0]  v_sel    [2];
    logic [3:0]  v_valid  [2];
    logic        v_oready [2];
    logic [31:0] v_data   [2][4];

    logic [127:0] d4_in;
    logic [95:0]  d3_in;
    logic [3:0]   rdy4;
    logic [2:0]   rdy3;
    logic [31:0]  od4, od3;
    logic         ov4, ov3;
    logic [1:0]   src4, src3;

    assign d4_in = {v_data[0][3], v_data[0][2], v_data[0][1], v_data[0][0]};
    assign d3_in = {v_data[1][2], v_data[1][1], v_data[1][0]};

    mux_n_1_pipe #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4_in), .in_valid(v_valid[0]),
        .in_ready(rdy4), .mode(v_mode[0]), .sel(v_sel[0]), .out_data(od4),
        .out_valid(ov4), .out_ready(v_oready[0]), .out_src(src4)
    );

    mux_n_1_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in), .in_valid(v_valid[1][2:0]),
        .in_ready(rdy3), .mode(v_mode[1]), .sel(v_sel[1]), .out_data(od3),
        .out_valid(ov3), .out_ready(v_oready[1]), .out_src(src3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference state: output register contents and round-robin pointer per instance.
    bit          m_ov  [2];
    logic [31:0] m_od  [2];
    int          m_os  [2];
    int          m_ptr [2];

    function automatic void mgrant(input int n, input bit md, input int s, input logic [3:0] v,
                                   input int p, output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (!md) begin
            if (s < n && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (p + k) % n;
                if (!gv && v[i]) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
    endfunction

    task automatic tick();
        bit          gv, acc;
        int          g, n;
        logic [3:0]  erdy, ordy;
        logic [31:0] obs_d;
        logic        obs_v;
        logic [1:0]  obs_s;
        bit          nov  [2];
        logic [31:0] nod  [2];
        int          nos  [2];
        int          nptr [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 4 : 3;
            mgrant(n, v_mode[d], int'(v_sel[d]), v_valid[d], m_ptr[d], gv, g);
            acc  = !m_ov[d] || v_oready[d];
            erdy = (rst_n && gv && acc) ? 4'(1 << g) : 4'b0;
            ordy  = (d == 0) ? rdy4 : {1'b0, rdy3};
            obs_v = (d == 0) ? ov4 : ov3;
            obs_d = (d == 0) ? od4 : od3;
            obs_s = (d == 0) ? src4 : src3;
            chk($sformatf("in_ready_n%0d", n), ordy, erdy);
            chk($sformatf("out_valid_n%0d", n), obs_v, m_ov[d]);
            chk($sformatf("out_data_n%0d", n), obs_d, m_od[d]);
            chk($sformatf("out_src_n%0d", n), obs_s, m_os[d]);
            nov[d]  = m_ov[d];
            nod[d]  = m_od[d];
            nos[d]  = m_os[d];
            nptr[d] = m_ptr[d];
            if (!rst_n) begin
                nov[d]  = 1'b0;
                nod[d]  = '0;
                nos[d]  = 0;
                nptr[d] = 0;
            end else if (gv && acc) begin
                nov[d] = 1'b1;
                nod[d] = v_data[d][g];
                nos[d] = g;
                if (v_mode[d]) nptr[d] = (g + 1) % n;
            end else if (m_ov[d] && v_oready[d]) begin
                nov[d] = 1'b0;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_ov[d]  = nov[d];
            m_od[d]  = nod[d];
            m_os[d]  = nos[d];
            m_ptr[d] = nptr[d];
        end
        #1;
    endtask

    int e4 [6] = '{0, 1, 2, 3, 0, 1};
    int e3 [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v_mode[d] = 1'b0; v_sel[d] = '0; v_valid[d] = '0; v_oready[d] = 1'b0;
            m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_ptr[d] = 0;
            for (int i = 0; i < 4; i++) v_data[d][i] = '0;
        end

        // Reset for two cycles, then fixed select of channel 2.
        tick(); tick();
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data", od4, 32'h0);
        chk("rst_in_ready", rdy4, 4'b0);
        v_sel[0] = 2'd2; v_valid[0] = 4'b0100; v_data[0][2] = 32'hDEAD_BEEF; v_oready[0] = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("fix_out_valid", ov4, 1'b1);
        chk("fix_out_data", od4, 32'hDEAD_BEEF);
        chk("fix_out_src", src4, 2'd2);
        chk("fix_in_ready", rdy4, 4'b0100);

        // Backpressure: held word must stay put, next word follows once released.
        v_oready[0] = 1'b0; v_data[0][2] = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_data", od4, 32'hDEAD_BEEF);
            chk("bp_in_ready", rdy4, 4'b0);
        end
        v_oready[0] = 1'b1;
        tick();
        chk("bp_next_data", od4, 32'h1234_5678);
        chk("bp_next_valid", ov4, 1'b1);
        v_valid[0] = 4'b0;
        tick();
        chk("bp_drain_valid", ov4, 1'b0);

        // Round-robin wrap on both instances.
        for (int d = 0; d < 2; d++) begin
            v_mode[d] = 1'b1; v_valid[d] = 4'b1111; v_oready[d] = 1'b1;
            for (int i = 0; i < 4; i++) v_data[d][i] = 32'h10 + i;
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rr4_src_%0d", c), src4, e4[c]);
            chk($sformatf("rr4_data_%0d", c), od4, 32'h10 + e4[c]);
            chk($sformatf("rr3_src_%0d", c), src3, e3[c]);
        end

        // Round-robin skip from ptr=1 with only channels 0 and 3 valid.
        v_valid[0] = 4'b0001;
        tick();
        chk("skip_setup_src", src4, 2'd0);
        v_valid[0] = 4'b1001;
        tick(); chk("skip_g0", src4, 2'd3);
        tick(); chk("skip_g1", src4, 2'd0);
        tick(); chk("skip_g2", src4, 2'd3);

        // Fixed mode leaves the pointer alone.
        v_valid[0] = 4'b0010;
        tick();
        v_mode[0] = 1'b0; v_sel[0] = 2'd1; v_valid[0] = 4'b1111;
        tick(); tick();
        chk("fix_keep_src", src4, 2'd1);
        v_mode[0] = 1'b1;
        tick();
        chk("ptr_held_src", src4, 2'd2);

        // Out-of-range select on N=3.
        v_mode[1] = 1'b0; v_sel[1] = 2'd3; v_valid[1] = 4'b0111;
        tick(); tick();
        chk("oor_in_ready", rdy3, 3'b0);
        chk("oor_out_valid", ov3, 1'b0);

        // Reset while a word is stalled.
        v_valid[0] = 4'b1111; v_oready[0] = 1'b0;
        tick(); tick();
        chk("stall_valid", ov4, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", ov4, 1'b0);
        chk("mid_rst_data", od4, 32'h0);
        rst_n = 1'b1; v_oready[0] = 1'b1;
        tick();
        chk("post_rst_src", src4, 2'd0);
        chk("post_rst_valid", ov4, 1'b1);

        // Random traffic, model-checked every cycle.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                v_mode[d]   = 1'($urandom_range(0, 1));
                v_sel[d]    = 2'($urandom_range(0, 3));
                v_valid[d]  = 4'($urandom_range(0, 15));
                v_oready[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) v_data[d][i] = $urandom;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
